// File: rtl/locker_session_arbiter.sv
// locker_session_arbiter: round-robin session controller sharing one digital_locker keypad port between NUM_REQ requesters.
// Optional audit counters (sess_count, fail_count) are enabled by defining LOCKER_ARB_AUDIT_EN.
module locker_session_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_pin,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   result_ok,
    output logic                   timeout,
    output logic                   busy,
    output logic                   lk_start,
    output logic                   lk_enter,
    output logic [3:0]             lk_keypad,
    input  logic                   lk_unlocked,
    input  logic                   lk_fail,
    input  logic                   lk_locked_out
`ifdef LOCKER_ARB_AUDIT_EN
    ,
    output logic [7:0]             sess_count,
    output logic [7:0]             fail_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_START, S_SEND, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_id;
    logic [15:0]         r_pin;
    logic [1:0]          r_digit;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       w_sel;
    logic [IW-1:0]       w_j;
    logic [NUM_REQ-1:0]  w_onehot;

    assign w_onehot = NUM_REQ'(1) << w_sel;

    // Pick the first pending requester at or above the round-robin pointer, wrapping around
    always_comb begin
        w_sel = '0;
        w_j   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req[w_j]) w_sel = w_j;
        end
    end

    // Session FSM; every output is a register updated on the state transition that enters its cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_pin     <= '0;
            r_digit   <= '0;
            r_cnt     <= '0;
            grant     <= '0;
            done      <= '0;
            result_ok <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            lk_start  <= 1'b0;
            lk_enter  <= 1'b0;
            lk_keypad <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lk_locked_out) begin
                        r_state <= S_HOLD;
                        busy    <= 1'b1;
                    end else if (|req) begin
                        r_state  <= S_START;
                        busy     <= 1'b1;
                        grant    <= w_onehot;
                        lk_start <= 1'b1;
                        r_id     <= w_sel;
                        r_pin    <= req_pin[{w_sel, 4'b0000} +: 16];
                    end
                end
                S_HOLD: begin
                    if (!lk_locked_out) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_START: begin
                    r_state   <= S_SEND;
                    lk_start  <= 1'b0;
                    lk_enter  <= 1'b1;
                    lk_keypad <= r_pin[15:12];
                    r_pin     <= {r_pin[11:0], 4'b0000};
                    r_digit   <= '0;
                end
                S_SEND: begin
                    if (r_digit == 2'd3) begin
                        r_state   <= S_WAIT;
                        lk_enter  <= 1'b0;
                        lk_keypad <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_digit   <= r_digit + 2'd1;
                        lk_keypad <= r_pin[15:12];
                        r_pin     <= {r_pin[11:0], 4'b0000};
                    end
                end
                S_WAIT: begin
                    if (lk_unlocked || lk_fail || r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_state   <= S_DONE;
                        done      <= grant;
                        result_ok <= lk_unlocked;
                        timeout   <= !lk_unlocked && !lk_fail;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    done      <= '0;
                    result_ok <= 1'b0;
                    timeout   <= 1'b0;
                    grant     <= '0;
                    busy      <= 1'b0;
                    r_rr_ptr  <= (r_id == IW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LOCKER_ARB_AUDIT_EN
    // Saturating session and failure counters, bumped during the DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sess_count <= '0;
            fail_count <= '0;
        end else if (r_state == S_DONE) begin
            sess_count <= (sess_count == 8'hFF) ? sess_count : sess_count + 8'd1;
            fail_count <= (result_ok || fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_locker_session_arbiter.sv
// tb_locker_session_arbiter: directed self-checking bench for locker_session_arbiter (NUM_REQ=3, TIMEOUT_CYC=16).
module tb_locker_session_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [47:0] req_pin = '0;
    logic [2:0]  grant, done;
    logic        result_ok, timeout, busy, lk_start, lk_enter;
    logic [3:0]  lk_keypad;
    logic        lk_unlocked = 1'b0, lk_fail = 1'b0, lk_locked_out = 1'b0;
`ifdef LOCKER_ARB_AUDIT_EN
    logic [7:0]  sess_count, fail_count;
`endif
    int checks = 0;
    int errors = 0;

    locker_session_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_pin(req_pin),
        .grant(grant), .done(done), .result_ok(result_ok), .timeout(timeout), .busy(busy),
        .lk_start(lk_start), .lk_enter(lk_enter), .lk_keypad(lk_keypad),
        .lk_unlocked(lk_unlocked), .lk_fail(lk_fail), .lk_locked_out(lk_locked_out)
`ifdef LOCKER_ARB_AUDIT_EN
        , .sess_count(sess_count), .fail_count(fail_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({grant, done, result_ok, timeout, busy, lk_start, lk_enter, lk_keypad} !== 15'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp 0", {grant, done, result_ok, timeout, busy, lk_start, lk_enter, lk_keypad});
        end
`ifdef LOCKER_ARB_AUDIT_EN
        checks++;
        if ({sess_count, fail_count} !== 16'h0) begin
            errors++;
            $display("FAIL reset_audit: got %h exp 0000", {sess_count, fail_count});
        end
`endif
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [15:0] pin;
        pin = 16'h4321;
        req_pin[15:0] = pin;
        req = 3'b001;
        tick();
        checks++;
        if ({grant, lk_start, busy} !== 5'b001_1_1) begin
            errors++;
            $display("FAIL single_start: got grant=%b start=%b busy=%b exp 001 1 1", grant, lk_start, busy);
        end
        for (int d = 0; d < 4; d++) begin
            tick();
            checks++;
            if ({lk_enter, lk_keypad} !== {1'b1, pin[15-4*d -: 4]}) begin
                errors++;
                $display("FAIL single_digit%0d: got enter=%b key=%h exp 1 %h", d, lk_enter, lk_keypad, pin[15-4*d -: 4]);
            end
        end
        tick();
        checks++;
        if ({lk_enter, busy, done} !== 5'b0_1_000) begin
            errors++;
            $display("FAIL single_wait: got enter=%b busy=%b done=%b exp 0 1 000", lk_enter, busy, done);
        end
        tick();
        tick();
        lk_unlocked = 1'b1;
        tick();
        lk_unlocked = 1'b0;
        req = 3'b000;
        checks++;
        if ({done, result_ok, timeout, grant} !== 8'b001_1_0_001) begin
            errors++;
            $display("FAIL single_done: got done=%b ok=%b to=%b grant=%b exp 001 1 0 001", done, result_ok, timeout, grant);
        end
        tick();
        checks++;
        if ({grant, done, busy} !== 7'b0) begin
            errors++;
            $display("FAIL single_idle: got grant=%b done=%b busy=%b exp 000 000 0", grant, done, busy);
        end
    endtask

    task automatic test_wrong_pin();
        req_pin[31:16] = 16'h1111;
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL wrong_grant: got %b exp 010", grant);
        end
        for (int d = 0; d < 4; d++) begin
            tick();
            checks++;
            if ({lk_enter, lk_keypad} !== 5'b1_0001) begin
                errors++;
                $display("FAIL wrong_digit%0d: got enter=%b key=%h exp 1 1", d, lk_enter, lk_keypad);
            end
        end
        tick();
        tick();
        tick();
        lk_fail = 1'b1;
        tick();
        lk_fail = 1'b0;
        req = 3'b000;
        checks++;
        if ({done, result_ok, timeout} !== 5'b010_0_0) begin
            errors++;
            $display("FAIL wrong_done: got done=%b ok=%b to=%b exp 010 0 0", done, result_ok, timeout);
        end
        tick();
`ifdef LOCKER_ARB_AUDIT_EN
        checks++;
        if ({sess_count, fail_count} !== {8'd2, 8'd1}) begin
            errors++;
            $display("FAIL wrong_audit: got sess=%0d fail=%0d exp 2 1", sess_count, fail_count);
        end
`endif
    endtask

    task automatic test_contention();
        int order [4] = '{0, 1, 2, 0};
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_pin = 48'h9999_8888_7777;
        req = 3'b111;
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++;
            if (grant !== 3'(1 << order[s])) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b exp %b", s, grant, 3'(1 << order[s]));
            end
            repeat (6) tick();
            lk_unlocked = 1'b1;
            lk_fail = (s == 0);
            tick();
            lk_unlocked = 1'b0;
            lk_fail = 1'b0;
            if (s == 3) req = 3'b000;
            checks++;
            if ({done, result_ok} !== {3'(1 << order[s]), 1'b1}) begin
                errors++;
                $display("FAIL contention_done%0d: got done=%b ok=%b exp %b 1", s, done, result_ok, 3'(1 << order[s]));
            end
            tick();
            checks++;
            if ({grant, done} !== 6'b0) begin
                errors++;
                $display("FAIL contention_gap%0d: got grant=%b done=%b exp 000 000", s, grant, done);
            end
        end
    endtask

    task automatic test_lockout();
        lk_locked_out = 1'b1;
        req = 3'b100;
        tick();
        checks++;
        if ({grant, busy, lk_start} !== 5'b000_1_0) begin
            errors++;
            $display("FAIL lockout_hold: got grant=%b busy=%b start=%b exp 000 1 0", grant, busy, lk_start);
        end
        tick();
        tick();
        checks++;
        if ({grant, busy} !== 4'b000_1) begin
            errors++;
            $display("FAIL lockout_stay: got grant=%b busy=%b exp 000 1", grant, busy);
        end
        lk_locked_out = 1'b0;
        tick();
        checks++;
        if ({grant, busy} !== 4'b0) begin
            errors++;
            $display("FAIL lockout_idle: got grant=%b busy=%b exp 000 0", grant, busy);
        end
        tick();
        checks++;
        if ({grant, lk_start} !== 4'b100_1) begin
            errors++;
            $display("FAIL lockout_serve: got grant=%b start=%b exp 100 1", grant, lk_start);
        end
        repeat (6) tick();
        lk_fail = 1'b1;
        tick();
        lk_fail = 1'b0;
        req = 3'b000;
        checks++;
        if ({done, result_ok} !== 4'b100_0) begin
            errors++;
            $display("FAIL lockout_done: got done=%b ok=%b exp 100 0", done, result_ok);
        end
        tick();
    endtask

    task automatic test_timeout();
        req = 3'b001;
        repeat (21) tick();
        checks++;
        if ({done, busy} !== 4'b000_1) begin
            errors++;
            $display("FAIL timeout_early: got done=%b busy=%b exp 000 1", done, busy);
        end
        tick();
        req = 3'b000;
        checks++;
        if ({done, timeout, result_ok} !== 5'b001_1_0) begin
            errors++;
            $display("FAIL timeout_done: got done=%b to=%b ok=%b exp 001 1 0", done, timeout, result_ok);
        end
        tick();
    endtask

    task automatic test_reset_mid_send();
        req = 3'b001;
        tick();
        tick();
        tick();
        checks++;
        if (lk_enter !== 1'b1) begin
            errors++;
            $display("FAIL midsend_enter: got %b exp 1", lk_enter);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({grant, done, result_ok, timeout, busy, lk_start, lk_enter, lk_keypad} !== 15'b0) begin
            errors++;
            $display("FAIL midsend_async: got %b exp 0", {grant, done, result_ok, timeout, busy, lk_start, lk_enter, lk_keypad});
        end
        tick();
        checks++;
        if (done !== 3'b000) begin
            errors++;
            $display("FAIL midsend_nodone: got %b exp 000", done);
        end
        req = 3'b100;
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL midsend_regrant: got %b exp 100", grant);
        end
        repeat (6) tick();
        lk_unlocked = 1'b1;
        tick();
        lk_unlocked = 1'b0;
        req = 3'b000;
        checks++;
        if ({done, result_ok} !== 4'b100_1) begin
            errors++;
            $display("FAIL midsend_done: got done=%b ok=%b exp 100 1", done, result_ok);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrong_pin();
        test_contention();
        test_lockout();
        test_timeout();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/locker_session_arbiter.md
# locker_session_arbiter

Multi-requester session controller placed in front of `digital_locker`. It shares the locker's single keypad/command port between `NUM_REQ` requesters such as the front panel, the remote console and the service port. For each granted requester it sequences the start pulse and the four PIN digits into the locker, then waits for the verdict and returns a pass/fail/timeout result to that requester. Arbitration is round-robin, and new grants are withheld while the locker reports lockout.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `TIMEOUT_CYC`, 64: maximum cycles in WAIT before a session is declared timed out (≥ 8).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`==0 resets).
- `req`  in  NUM_REQ  per-requester session request, level, held until its `done`.
- `req_pin`  in  16*NUM_REQ  packed 4-nibble PIN; requester i uses bits [16i+15:16i], MS nibble = first digit.
- `grant`  out  NUM_REQ  one-hot, high from START through DONE of the owning session.
- `done`  out  NUM_REQ  one-cycle pulse to the owning requester at session end.
- `result_ok`  out  1  valid with `done`; 1 = locker unlocked.
- `timeout`  out  1  valid with `done`; 1 = no verdict within TIMEOUT_CYC.
- `busy`  out  1  high in every state except IDLE.
- `lk_start`  out  1  to locker `start`.
- `lk_enter`  out  1  to locker `enter`.
- `lk_keypad`  out  4  to locker `keypad_in`.
- `lk_unlocked`  in  1  from locker `unlocked`.
- `lk_fail`  in  1  from locker `fail`.
- `lk_locked_out`  in  1  from locker `locked_out`.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets `rr_ptr`=0, clears the PIN latch and the digit index, and sets state to IDLE. Reset asserted mid-session aborts the session immediately; no `done` is issued.
- States: IDLE, HOLD, START, SEND, WAIT, DONE.
- IDLE:
  - if `lk_locked_out` = 1, go to HOLD, regardless of `req`.
  - otherwise, if any `req` is set, select the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ. Latch its `req_pin` and its id, then go to START.
- HOLD: no grant issued. When `lk_locked_out` = 0, return to IDLE.
- START: one cycle. `lk_start`=1, `grant[id]`=1. Then go to SEND.
- SEND: four cycles with `lk_enter`=1. `lk_keypad` = pin[15:12], [11:8], [7:4], [3:0] in that order. Then go to WAIT with the wait counter at 0.
- WAIT, evaluated in priority order:
  - `lk_unlocked`: go to DONE with ok=1.
  - else `lk_fail`: go to DONE with ok=0.
  - else if counter == TIMEOUT_CYC-1: go to DONE with ok=0, timeout=1.
  - else increment the counter.
- DONE: one cycle. `done[id]`=1 with `result_ok`/`timeout` valid. Set `rr_ptr` = (id+1) mod NUM_REQ, then go to IDLE.
- `req`/`req_pin` changes after the PIN latch are ignored. A dropped `req` does not abort the session; `done` is still pulsed.
- `lk_locked_out` is sampled only in IDLE. A tamper event during a session resolves through `lk_fail` or timeout.
- Simultaneous requests are resolved by `rr_ptr` only. A requester re-requesting immediately after its `done` waits behind all other pending requesters.

## Timing
- `req` sampled high in IDLE at cycle T. Then:
  - `grant` and `lk_start` high in cycle T+1.
  - `lk_enter` high in cycles T+2..T+5.
  - WAIT entered at T+6.
- With `digital_locker` attached, the verdict is visible at T+8 and `done` pulses at T+9, giving a minimum session length of 9 cycles.
- A timed-out session has `done` at T+6+TIMEOUT_CYC.
- Back-to-back sessions: the next grant is issued 2 cycles after `done`, because IDLE occupies one cycle.
- `grant` falls in the cycle after DONE.

## Configuration
- `LOCKER_ARB_AUDIT_EN` defined adds two outputs, both 8-bit, saturating at 255, reset to 0:
  - `sess_count`: increments on every `done`.
  - `fail_count`: increments on every `done` with `result_ok`=0.
- `LOCKER_ARB_AUDIT_EN` undefined: neither port nor either counter exists. All other behaviour is identical.

## Test plan
- Single requester: `req[0]`=1, pin 0x4321, locker at its default PIN → `lk_keypad` 4,3,2,1 in T+2..T+5; `done[0]` at T+9 with `result_ok`=1, `timeout`=0.
- Wrong PIN: `req[1]`=1, pin 0x1111 → `done[1]` with `result_ok`=0. With `LOCKER_ARB_AUDIT_EN`, `fail_count`=1 and `sess_count`=1.
- Contention: `req`=3'b111 held continuously → grant order 0,1,2,0. Each `done` precedes the next grant by 2 cycles.
- Lockout: three wrong sessions, or `tamper` pulsed on the locker → arbiter sits in HOLD with `grant`=0 and `busy`=1 until the locker's `locked_out` clears, then serves the pending `req`.
- Timeout: locker model that never asserts `unlocked`/`fail`, TIMEOUT_CYC=16 → `done` at T+22 with `timeout`=1, `result_ok`=0.
- Reset mid-SEND: drive `rst`=0 at T+3 → all outputs 0 immediately, no `done` issued. After release, a new `req[2]` is granted first because `rr_ptr`=0 and only bit 2 is set.
